// File: rtl/alu_issue_seq.sv
// Issue sequencer for the combinational ripple ALU: registers one op, captures the ALU outputs, returns them on a valid/ready port.
// Optional shift-add 32x32 multiply over the ALU's ADD, compiled in with ALU_ISSUE_SEQ_MUL_EN.
module alu_issue_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef ALU_ISSUE_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;
  logic             simple_op;

`ifdef ALU_ISSUE_SEQ_MUL_EN
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d, acc_nxt;
  logic [4:0]       cnt_q, cnt_d;
`endif

  always_comb begin
    case (req_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: simple_op = 1'b1;
      default:                                       simple_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      src1_q   <= '0;
      src2_q   <= '0;
      ctrl_q   <= 4'b0000;
      res_q    <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_ISSUE_SEQ_MUL_EN
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      ctrl_q   <= ctrl_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef ALU_ISSUE_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    ctrl_d   = ctrl_q;
    res_d    = res_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
`ifdef ALU_ISSUE_SEQ_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_nxt  = mplier_q[0] ? alu_result : acc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ctrl_d = req_op;
          src1_d = req_a;
          src2_d = req_b;
          if (simple_op) begin
            state_d = S_EXEC;
`ifdef ALU_ISSUE_SEQ_MUL_EN
          end else if (req_op == OP_MUL) begin
            // The ALU must already see acc=0 + mcand under ADD in the first iteration.
            ctrl_d   = OP_ADD;
            src1_d   = '0;
            src2_d   = req_a;
            acc_d    = '0;
            mcand_d  = req_a;
            mplier_d = req_b;
            cnt_d    = '0;
            state_d  = S_MUL;
`endif
          end else begin
            res_d   = '0;
            zero_d  = 1'b0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        cout_d  = alu_cout;
        ovf_d   = alu_overflow;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
`ifdef ALU_ISSUE_SEQ_MUL_EN
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        src1_d   = acc_nxt;
        src2_d   = mcand_q << 1;
        if (cnt_q == 5'd31) begin
          res_d   = acc_nxt;
          zero_d  = (acc_nxt == '0);
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign alu_src1   = src1_q;
  assign alu_src2   = src2_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_cout   = cout_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: behavioural ALU stub, directed vector table, backpressure/reset sequences, randomized ops vs reference.
`timescale 1ns/1ps
module tb_alu_issue_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req_op, alu_ctrl;
  logic [31:0] req_a, req_b, alu_src1, alu_src2, alu_result, rsp_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        rsp_zero, rsp_cout, rsp_ovf, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  alu_issue_seq #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
  );

  typedef struct packed {
    logic [31:0] r;
    logic        z, c, o;
  } alu_out_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z, c, o, e;
    int          lat;
  } vec_t;

  // Behavioural model of the ripple ALU the sequencer drives.
  function automatic alu_out_t alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_out_t    y;
    logic [32:0] s;
    y = '0;
    s = '0;
    case (op)
      4'b0000: y.r = a & b;
      4'b0001: y.r = a | b;
      4'b0010: begin
        s   = {1'b0, a} + {1'b0, b};
        y.r = s[31:0];
        y.c = s[32];
        y.o = (a[31] == b[31]) && (y.r[31] != a[31]);
      end
      4'b0110: begin
        s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        y.r = s[31:0];
        y.c = s[32];
        y.o = (a[31] != b[31]) && (y.r[31] != a[31]);
      end
      4'b0111: y.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: y.r = ~(a | b);
      default: y.r = 32'd0;
    endcase
    y.z = (y.r == 32'd0);
    return y;
  endfunction

  assign {alu_result, alu_zero, alu_cout, alu_overflow} = alu_model(alu_ctrl, alu_src1, alu_src2);

  function automatic bit mul_en();
`ifdef ALU_ISSUE_SEQ_MUL_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic vec_t ref_rsp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    vec_t     v;
    alu_out_t y;
    v.op = op; v.a = a; v.b = b;
    v.res = '0; v.z = 0; v.c = 0; v.o = 0; v.e = 0; v.lat = 0;
    if (op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100}) begin
      y = alu_model(op, a, b);
      v.res = y.r; v.z = y.z; v.c = y.c; v.o = y.o; v.lat = 1;
    end else if (op == 4'b1000 && mul_en()) begin
      v.res = a * b;
      v.z   = (v.res == 32'd0);
      v.lat = 32;
    end else begin
      v.e = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string tag, input vec_t e, input int hold);
    int          w;
    int          lat;
    logic [31:0] held;
    @(negedge clk_i);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = e.op;
    req_a     = e.a;
    req_b     = e.b;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid = 1'b0;
    req_a     = $urandom;
    req_b     = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    chk({tag, ".lat"}, lat, e.lat);
    chk({tag, ".res"}, rsp_result, e.res);
    chk({tag, ".flags"}, {28'd0, rsp_zero, rsp_cout, rsp_ovf, rsp_err}, {28'd0, e.z, e.c, e.o, e.e});
    held = rsp_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk({tag, ".hold_res"}, rsp_result, held);
      chk({tag, ".hold_rdy_vld"}, {30'd0, req_ready, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk({tag, ".after_xfer"}, {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    int          lat_dummy;
    int          seen;
    logic [3:0]  ops [10];
    logic [3:0]  op;
    logic [31:0] a, b;

    rst_i = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 4'd0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset.rdy_vld", {30'd0, req_ready, rsp_valid}, 32'd2);
    chk("reset.rsp", {rsp_result[27:0], rsp_zero, rsp_cout, rsp_ovf, rsp_err}, 32'd0);
    chk("reset.alu", {alu_src1[27:0] | alu_src2[27:0], alu_ctrl}, 32'd0);
    rst_i = 1'b0;

    tbl.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 1});
    tbl.push_back('{4'b0110, 32'd5, 32'd5, 32'd0, 1, 1, 0, 0, 1});
    tbl.push_back('{4'b0111, 32'hFFFFFFFD, 32'd2, 32'd1, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b1100, 32'd0, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'd0, 0, 0, 0, 1, 0});
    tbl.push_back('{4'b0011, 32'd7, 32'd9, 32'd0, 0, 0, 0, 1, 0});
    if (mul_en()) begin
      tbl.push_back('{4'b1000, 32'd123, 32'd456, 32'd56088, 0, 0, 0, 0, 32});
      tbl.push_back('{4'b1000, 32'h10000, 32'h10000, 32'd0, 1, 0, 0, 0, 32});
      tbl.push_back('{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 0, 32});
    end else begin
      tbl.push_back('{4'b1000, 32'd123, 32'd456, 32'd0, 0, 0, 0, 1, 0});
    end
    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i], 0);

    run_op("bp_or", '{4'b0001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 0, 0, 0, 0, 1}, 5);

    // Reset in the middle of an operation: MUL iteration 10, or RESP without MUL.
    @(negedge clk_i);
    req_valid = 1'b1;
    req_op    = mul_en() ? 4'b1000 : 4'b0010;
    req_a     = 32'hFFFF;
    req_b     = 32'hFFFF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid = 1'b0;
    lat_dummy = mul_en() ? 10 : 1;
    repeat (lat_dummy) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_mid.rdy_vld", {30'd0, req_ready, rsp_valid}, 32'd2);
    rsp_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    chk("rst_mid.no_rsp", seen, 0);
    run_op("post_rst_add", '{4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1}, 0);

    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1111, 4'b0011, 4'b1001};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      v  = ref_rsp(op, a, b);
      run_op($sformatf("rnd%0d_op%0h", i, op), v, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Request-side sequencer for the 32-bit ripple ALU. Accepts one operation per valid/ready handshake and drives the ALU's `src1`/`src2`/`ALU_control` from registered operands. Captures the ALU's `result`/`zero`/`cout`/`overflow` and returns them on a valid/ready response port. Sits between the decode stage and the ALU, and optionally iterates the ALU's ADD to form a 32x32 multiply.

## Interface
Parameters:
- WIDTH, 32, datapath width; must match the ALU.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  4  ALU_control encoding: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL (config-dependent).
- req_a, req_b  in  WIDTH  operands.
- alu_src1, alu_src2  out  WIDTH  registered operands to the ALU.
- alu_ctrl  out  4  to the ALU's `ALU_control`.
- alu_result  in  WIDTH  combinational ALU result.
- alu_zero, alu_cout, alu_overflow  in  1  combinational ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero, rsp_cout, rsp_ovf, rsp_err  out  1  captured flags; err marks an illegal op.

## Operation
- States: IDLE, EXEC, MUL, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_op` to `alu_ctrl` and `req_a`/`req_b` to `alu_src1`/`alu_src2`.
  - Legal non-MUL op → EXEC. MUL with MUL compiled in → MUL. Any other op → RESP with `rsp_err`=1, result 0, flags 0.
- EXEC: the ALU sees stable registered inputs for the full cycle. At the edge, capture `alu_result`/`alu_zero`/`alu_cout`/`alu_overflow` into the `rsp_*` registers with `rsp_err`=0. Go to RESP.
- MUL (shift-add):
  - Internal regs: acc, mcand, mplier, 5-bit cnt.
  - On entry: acc=0, mcand=a, mplier=b, cnt=0.
  - Each cycle: `alu_src1`=acc, `alu_src2`=mcand, `alu_ctrl`=0010.
  - At the edge: if mplier[0], acc←`alu_result`. Then mcand←mcand<<1, mplier←mplier>>1, cnt+1.
  - After cnt=31 is processed, capture: `rsp_result`=acc (low 32 bits, wraps modulo 2^32), `rsp_zero`=(acc==0), `rsp_cout`=0, `rsp_ovf`=0. Go to RESP.
- RESP:
  - `rsp_valid`=1. Outputs are held stable while `rsp_ready`=0.
  - On `rsp_ready`, go to IDLE. No request is accepted in the same cycle.
- `alu_ctrl`, `alu_src1`, `alu_src2` hold their last values outside EXEC/MUL. The ALU is purely combinational, so stale drive is harmless.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1, `rsp_valid`=0.
  - `rsp_result`=0 and all `rsp_*` flags 0.
  - `alu_src1`=`alu_src2`=0, `alu_ctrl`=0000.
  - acc/mcand/mplier/cnt=0.
- Latency:
  - Simple op: accepted at edge k; EXEC during cycle k→k+1; `rsp_valid` high after edge k+1.
  - MUL: `rsp_valid` high after edge k+32.
  - Illegal op: `rsp_valid` high after edge k.
- Throughput: at most one simple op per 3 cycles with `rsp_ready` tied high.
- Handshake: transfer when valid&ready at a rising edge. `req_ready` is a pure function of state.
- Reset mid-operation (EXEC, MUL or RESP): the block returns to IDLE on that edge; the pending response is dropped and never presented.
- SLT: the block passes through the ALU's result unmodified. Correctness of bit0 is the ALU's responsibility.
- `req_op` values other than the six legal ops (and MUL when enabled) are illegal; the response follows the IDLE rules above.

## Configuration
- `ALU_ISSUE_SEQ_MUL_EN` defined: MUL state, acc/mcand/mplier/cnt registers and op 1000 are compiled in, as described above.
- Undefined: MUL state and registers are absent. Op 1000 is illegal (`rsp_err`=1, 1-cycle path). All other behaviour is identical.

## Test plan
- ADD: a=0x7FFFFFFF, b=0x00000001 → `rsp_result`=0x80000000, ovf=1, cout=0, zero=0; `rsp_valid` exactly 1 cycle after the accept edge.
- SUB: a=5, b=5 → result 0, zero=1, cout=1, ovf=0. SLT: a=0xFFFFFFFD, b=2 → result 1.
- MUL (macro defined): 123×456 → result 56088, `rsp_valid` 32 cycles after accept. 0x10000×0x10000 → result 0, zero=1.
- Illegal op 1111, and op 1000 with macro undefined → `rsp_err`=1, result 0, `rsp_valid` after accept edge, ALU never enters EXEC.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after an OR of 0xF0F0F0F0|0x0F0F0F0F → `rsp_result` stays 0xFFFFFFFF and `req_ready` stays 0 until the transfer.
- Reset: assert `rst_i` for 1 cycle at MUL iteration 10 → next cycle IDLE, `req_ready`=1, `rsp_valid` never asserts; a following ADD 2+3 returns 5.
